// File: rtl/sap1_pkg.sv
// sap1_pkg -- shared types and defaults for the SAP-1 memory address register.
//   mar_state_e : FSM encoding of mar_burst (IDLE, BURST, DONE)
//   SAP1_ADDR_W : default address width (address space 2**SAP1_ADDR_W words)
//   SAP1_LEN_W  : default burst length field width
package sap1_pkg;

  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } mar_state_e;

endpackage

// File: rtl/mar_beat_counter.sv
// mar_beat_counter -- loadable down-counter tracking the beats left in a burst.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   load     in   capture len into the counter (has priority over dec)
//   len      in   LEN_W  beat count to load
//   dec      in   decrement by one (saturates at zero)
//   last     out  count == 1: the next accepted beat is the final one
//   zero     out  count == 0
module mar_beat_counter
  import sap1_pkg::*;
#(
  parameter int LEN_W = SAP1_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             dec,
  output logic             last,
  output logic             zero
);

  logic [LEN_W-1:0] count_reg;
  logic [LEN_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = len;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign last = (count_reg == LEN_W'(1));
  assign zero = (count_reg == '0);

endmodule

// File: rtl/mar_burst.sv
// mar_burst -- SAP-1 memory address register with self-increment and an
// autonomous sequential burst toward RAM using a valid/ready handshake.
// Optional feature macro: MAR_BURST_ABORT_EN (adds burst_abort / aborted).
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   w_bus        in   ADDR_W  address source from the W bus
//   load         in   capture w_bus (IDLE only)
//   inc          in   MAR <= MAR+1 (IDLE only, load wins)
//   burst_start  in   start a burst from MAR (or w_bus when load is also high)
//   burst_len    in   LEN_W  beat count sampled with burst_start
//   mem_ready    in   RAM accepts the offered address this cycle
//   mar_address  out  ADDR_W  current address (registered)
//   addr_valid   out  high in BURST
//   busy         out  high in BURST and DONE
//   burst_done   out  one-cycle pulse in DONE
//   ovf          out  one-cycle pulse after an increment wraps all-ones -> 0
//   burst_abort  in   (MAR_BURST_ABORT_EN) end the burst early
//   aborted      out  (MAR_BURST_ABORT_EN) pulses with burst_done on an abort
module mar_burst
  import sap1_pkg::*;
#(
  parameter int ADDR_W = SAP1_ADDR_W,
  parameter int LEN_W  = SAP1_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] w_bus,
  input  logic              load,
  input  logic              inc,
  input  logic              burst_start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mar_address,
  output logic              addr_valid,
  output logic              busy,
  output logic              burst_done,
  output logic              ovf
`ifdef MAR_BURST_ABORT_EN
 ,input  logic              burst_abort,
  output logic              aborted
`endif
);

  mar_state_e        state_reg;
  mar_state_e        state_next;
  logic [ADDR_W-1:0] mar_reg;
  logic [ADDR_W-1:0] mar_next;
  logic              ovf_reg;
  logic              ovf_next;
  logic              step_en;
  logic              abort_hit;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_last;
  logic              cnt_zero;

`ifdef MAR_BURST_ABORT_EN
  logic aborted_reg;
  assign abort_hit = (state_reg == BURST) && burst_abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Remaining-beat counter: loaded on every burst_start accepted in IDLE,
  // decremented on every accepted beat.
  assign cnt_load = (state_reg == IDLE) && burst_start;
  assign cnt_dec  = (state_reg == BURST) && mem_ready && !cnt_zero;

  mar_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .len     (burst_len),
    .dec     (cnt_dec),
    .last    (cnt_last),
    .zero    (cnt_zero)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (burst_start) begin
          // A zero-length burst skips straight to DONE so the sequencer
          // still sees a completion pulse.
          state_next = (burst_len != '0) ? BURST : DONE;
        end
      end
      BURST: begin
        if (abort_hit || (mem_ready && cnt_last)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    addr_valid = 1'b0;
    busy       = 1'b0;
    burst_done = 1'b0;
    case (state_reg)
      BURST: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        busy       = 1'b1;
        burst_done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Address register ----------------
  // In IDLE, burst_start without load suppresses inc so the burst base is the
  // MAR value the sequencer saw, not MAR+1.
  always_comb begin
    mar_next = mar_reg;
    step_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          mar_next = w_bus;
        end else if (inc && !burst_start) begin
          step_en = 1'b1;
        end
      end
      BURST: begin
        // A beat accepted in the same cycle as an abort still advances.
        step_en = mem_ready;
      end
      default: ;
    endcase
    if (step_en) begin
      mar_next = mar_reg + ADDR_W'(1);
    end
    ovf_next = step_en && (&mar_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mar_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      mar_reg <= mar_next;
      ovf_reg <= ovf_next;
    end
  end

  assign mar_address = mar_reg;
  assign ovf         = ovf_reg;

`ifdef MAR_BURST_ABORT_EN
  // Set on the BURST->DONE edge caused by an abort, so it lines up with
  // burst_done in DONE and clears on the following edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= abort_hit;
    end
  end

  assign aborted = aborted_reg;
`endif

endmodule

// File: tb/tb_mar_burst.sv
// tb_mar_burst -- self-checking bench for mar_burst. Expected beat addresses are
// queued when a burst is launched and popped by a monitor on every accepted beat.
// Abort coverage is compiled when MAR_BURST_ABORT_EN is defined.
module tb_mar_burst;

  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] w_bus;
  logic              load;
  logic              inc;
  logic              burst_start;
  logic [LEN_W-1:0]  burst_len;
  logic              mem_ready;
  logic [ADDR_W-1:0] mar_address;
  logic              addr_valid;
  logic              busy;
  logic              burst_done;
  logic              ovf;
`ifdef MAR_BURST_ABORT_EN
  logic              burst_abort;
  logic              aborted;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;
  logic [ADDR_W-1:0] beat_q[$];

  mar_burst #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .w_bus       (w_bus),
    .load        (load),
    .inc         (inc),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .mem_ready   (mem_ready),
    .mar_address (mar_address),
    .addr_valid  (addr_valid),
    .busy        (busy),
    .burst_done  (burst_done),
    .ovf         (ovf)
`ifdef MAR_BURST_ABORT_EN
   ,.burst_abort (burst_abort),
    .aborted     (aborted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every accepted beat must match the next queued address.
  always @(negedge clk) begin
    if (reset_n) begin
      if (burst_done) done_cnt++;
      if (ovf) ovf_cnt++;
      if (addr_valid && mem_ready) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", {28'd0, mar_address}, 32'hFFFF_FFFF);
        end else begin
          check("beat_addr", {28'd0, mar_address}, {28'd0, beat_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int d0;
    int o0;
    logic [3:0] rdy_pat;
    logic [ADDR_W-1:0] hold_exp;

    reset_n     = 1'b0;
    w_bus       = '0;
    load        = 1'b0;
    inc         = 1'b0;
    burst_start = 1'b0;
    burst_len   = '0;
    mem_ready   = 1'b0;
`ifdef MAR_BURST_ABORT_EN
    burst_abort = 1'b0;
`endif
    step();
    step();
    check("rst_mar", {28'd0, mar_address}, 32'd0);
    check("rst_valid", {31'd0, addr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, burst_done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    reset_n = 1'b1;
    step();

    // load A, then inc twice
    o0 = ovf_cnt;
    w_bus = 4'hA; load = 1'b1;
    step();
    load = 1'b0;
    check("load_A", {28'd0, mar_address}, 32'hA);
    inc = 1'b1;
    step();
    check("inc_B", {28'd0, mar_address}, 32'hB);
    step();
    check("inc_C", {28'd0, mar_address}, 32'hC);
    inc = 1'b0;
    check("inc_no_ovf", ovf_cnt - o0, 32'd0);

    // burst of 3 from E with wrap
    w_bus = 4'hE; load = 1'b1;
    step();
    load = 1'b0;
    d0 = done_cnt; o0 = ovf_cnt;
    burst_start = 1'b1; burst_len = 4'd3; mem_ready = 1'b1;
    beat_q.push_back(4'hE); beat_q.push_back(4'hF); beat_q.push_back(4'h0);
    step();
    burst_start = 1'b0;
    check("b3_valid", {31'd0, addr_valid}, 32'd1);
    step();
    step();
    check("b3_wrap_mar", {28'd0, mar_address}, 32'h0);
    check("b3_ovf", {31'd0, ovf}, 32'd1);
    step();
    check("b3_done", {31'd0, burst_done}, 32'd1);
    check("b3_final_mar", {28'd0, mar_address}, 32'h1);
    mem_ready = 1'b0;
    wait_idle(10);
    check("b3_done_cnt", done_cnt - d0, 32'd1);
    check("b3_ovf_cnt", ovf_cnt - o0, 32'd1);

    // burst of 2 from 3 with mem_ready pattern 0,1,0,0,1
    w_bus = 4'h3; load = 1'b1;
    step();
    load = 1'b0;
    d0 = done_cnt;
    burst_start = 1'b1; burst_len = 4'd2;
    beat_q.push_back(4'h3); beat_q.push_back(4'h4);
    step();
    burst_start = 1'b0;
    rdy_pat = 4'b0010;
    hold_exp = 4'h3;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4) ? 1'b1 : rdy_pat[i];
      check("b2_hold", {28'd0, mar_address}, {28'd0, hold_exp});
      step();
      if (mem_ready) hold_exp = hold_exp + 4'd1;
    end
    mem_ready = 1'b0;
    check("b2_done", {31'd0, burst_done}, 32'd1);
    check("b2_final_mar", {28'd0, mar_address}, 32'h5);
    wait_idle(10);
    check("b2_done_cnt", done_cnt - d0, 32'd1);

    // zero-length burst
    burst_start = 1'b1; burst_len = 4'd0;
    step();
    burst_start = 1'b0;
    check("b0_done", {31'd0, burst_done}, 32'd1);
    check("b0_valid", {31'd0, addr_valid}, 32'd0);
    step();
    check("b0_idle", {31'd0, busy}, 32'd0);
    check("b0_mar", {28'd0, mar_address}, 32'h5);

    // same-cycle load + burst_start, single beat at 7
    w_bus = 4'h7; load = 1'b1; burst_start = 1'b1; burst_len = 4'd1; mem_ready = 1'b1;
    beat_q.push_back(4'h7);
    step();
    load = 1'b0; burst_start = 1'b0;
    check("b1_mar", {28'd0, mar_address}, 32'h7);
    step();
    mem_ready = 1'b0;
    check("b1_done", {31'd0, burst_done}, 32'd1);
    check("b1_final_mar", {28'd0, mar_address}, 32'h8);
    wait_idle(10);

    // load/inc ignored during BURST
    burst_start = 1'b1; burst_len = 4'd2;
    beat_q.push_back(4'h8); beat_q.push_back(4'h9);
    step();
    burst_start = 1'b0;
    w_bus = 4'hF; load = 1'b1; inc = 1'b1;
    step();
    load = 1'b0; inc = 1'b0;
    check("ign_mar", {28'd0, mar_address}, 32'h8);
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    check("ign_done", {31'd0, burst_done}, 32'd1);
    check("ign_final_mar", {28'd0, mar_address}, 32'hA);
    wait_idle(10);

`ifdef MAR_BURST_ABORT_EN
    // abort after one of four beats
    w_bus = 4'h2; load = 1'b1; burst_start = 1'b1; burst_len = 4'd4; mem_ready = 1'b1;
    beat_q.push_back(4'h2);
    step();
    load = 1'b0; burst_start = 1'b0;
    step();
    mem_ready = 1'b0; burst_abort = 1'b1;
    step();
    burst_abort = 1'b0;
    check("abt_done", {31'd0, burst_done}, 32'd1);
    check("abt_aborted", {31'd0, aborted}, 32'd1);
    check("abt_mar", {28'd0, mar_address}, 32'h3);
    step();
    check("abt_aborted_clr", {31'd0, aborted}, 32'd0);
    check("abt_idle", {31'd0, busy}, 32'd0);
`endif

    // asynchronous reset mid-burst
    burst_start = 1'b1; burst_len = 4'd4; mem_ready = 1'b0;
    step();
    burst_start = 1'b0;
    check("mid_valid", {31'd0, addr_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_mar", {28'd0, mar_address}, 32'd0);
    check("mid_rst_valid", {31'd0, addr_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    reset_n = 1'b1; inc = 1'b1;
    step();
    inc = 1'b0;
    check("post_rst_inc", {28'd0, mar_address}, 32'd1);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    check("queue_empty", beat_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
